board_redraw_scheduler: RTL
===========================

Name: board_redraw_scheduler

Overview:
Sequences the single-tile drawer over the 16 tiles of the 4x4 game board. It takes board snapshots from game logic and tracks which tiles changed since they were last drawn. It then issues one start/done transaction per dirty tile to the tile drawer, lowest index first. It sits between game logic and the tile drawer, and is the only block that drives the drawer's start, index and value inputs.

Parameters:
TIMEOUT_CYCLES, 20000, cycles to wait for sq_draw_done before abandoning a tile.
TILE_W, 4, bits per tile value, equal to the drawer's value width.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset; asserted when 0
board  in  16*TILE_W  packed board; tile i occupies board[i*TILE_W +: TILE_W]
board_valid  in  1  one-cycle strobe; samples board
full_redraw  in  1  one-cycle strobe; marks all 16 tiles dirty
sq_start  out  1  one-cycle start pulse to the tile drawer
sq_index  out  4  tile index to draw
sq_value  out  TILE_W  tile value to draw
sq_draw_done  in  1  drawer completion pulse
busy  out  1  high whenever state is not IDLE
pass_done  out  1  one-cycle pulse when the dirty set drains to empty
timeout_err  out  1  sticky; set on any drawer timeout

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; pending=0; shadow=0; dirty=16'hFFFF (the full board is drawn after reset).
  - timeout counter=0; sq_start=0; sq_index=0; sq_value=0; busy=0; pass_done=0; timeout_err=0.
- Capture: on board_valid, pending<=board. In the same edge, dirty[i] is set for every i where board tile i != shadow tile i. full_redraw sets all dirty bits. Both may fire in the same cycle; effects OR together.
- States: IDLE, SCAN, LAUNCH, WAIT.
  - IDLE: go to SCAN when dirty!=0.
  - SCAN: idx <= lowest set bit of dirty (evaluated after any same-cycle capture).
    - If dirty==0: go to IDLE and pulse pass_done for one cycle.
    - Otherwise go to LAUNCH.
  - LAUNCH (exactly 1 cycle):
    - sq_start=1; sq_index=idx; sq_value=pending tile idx (registered at SCAN exit, stable until the next LAUNCH).
    - shadow tile idx <= that value; dirty[idx] cleared; timeout counter cleared.
    - Go to WAIT.
  - WAIT:
    - On sq_draw_done: go to SCAN.
    - On counter==TIMEOUT_CYCLES-1: set timeout_err, re-set dirty[idx], go to SCAN.
    - Counter saturates; it never wraps.
- Latency: board_valid at edge t with busy=0 gives state=SCAN at t+1, and sq_start is high during the cycle after t+2. Minimum per-tile turnaround is 3 cycles plus drawer time.
- Simultaneous events:
  - A capture-set and a LAUNCH-clear of the same dirty bit in one cycle: the set wins.
  - A board change during WAIT to the tile being drawn marks it dirty again (compare is against the updated shadow), so it is redrawn later.
  - sq_draw_done outside WAIT is ignored.
- sq_index/sq_value remain stable from LAUNCH through WAIT.
- Reset mid-draw: outputs drop immediately; everything is redrawn after release.
- pass_done does not fire when leaving IDLE→SCAN→IDLE is impossible (IDLE exits only with dirty!=0). It fires once per drain.

Optional Feature:
DIRTY_TRACK_EN.
- Defined: per-tile compare against shadow, as above; only changed tiles are redrawn.
- Undefined: the shadow register and comparators are omitted, and every board_valid sets dirty=16'hFFFF (all 16 tiles redrawn). Port list and handshake are unchanged.

Decomposition:
- Package draw_pkg: BOARD_TILES=16, INDEX_W=4, the sched_state_t enum {IDLE,SCAN,LAUNCH,WAIT}, and a tile-extraction function.
- Sub-module tile_prio_enc: combinational 16-bit lowest-set-bit encoder with outputs idx[3:0] and any.

Test Plan:
- Reset release with drawer done after 5 cycles each → 16 sq_start pulses with index 0..15 in order, values 0, then a single pass_done, then busy=0.
- Idle, board_valid changing only tiles 3 (→2) and 9 (→4) → exactly two launches: (3,2) then (9,4); pass_done once.
- During WAIT on tile 3, board_valid sets tile 3 to 8 → tile 3 is relaunched with value 8 after the current draw; no other tiles drawn.
- Drawer never returns done, TIMEOUT_CYCLES=50 → timeout_err rises 50 cycles after LAUNCH, the same index is relaunched, and timeout_err stays high.
- full_redraw while idle with an unchanged board → 16 launches. Without DIRTY_TRACK_EN, board_valid with an identical board also gives 16 launches.
- Reset asserted mid-WAIT → sq_start=0 and busy=0 asynchronously; after release the board redraws from index 0.

Source files
------------

// File: rtl/draw_pkg.sv
// draw_pkg: shared constants, scheduler state type and a tile extraction
// helper for the board redraw scheduler and its priority encoder.
package draw_pkg;

  localparam int BOARD_TILES  = 16;
  localparam int INDEX_W      = 4;
  // Widest tile value the extraction helper supports.
  localparam int MAX_TILE_W   = 8;
  localparam int WIDE_BOARD_W = BOARD_TILES * MAX_TILE_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    LAUNCH = 2'd2,
    WAIT   = 2'd3
  } sched_state_t;

  // Returns tile i of a packed board whose tiles are w bits wide. The board
  // is passed zero-extended to the widest supported layout.
  function automatic logic [MAX_TILE_W-1:0] tile_get(
    input logic [WIDE_BOARD_W-1:0] b,
    input int unsigned             w,
    input logic [INDEX_W-1:0]      i
  );
    logic [WIDE_BOARD_W-1:0] shifted;
    shifted = b >> (w * 32'(i));
    return shifted[MAX_TILE_W-1:0] & ~({MAX_TILE_W{1'b1}} << w);
  endfunction

endpackage

// File: rtl/tile_prio_enc.sv
// tile_prio_enc: combinational lowest-set-bit encoder over the 16 dirty
// flags. 'any' is low when no tile is dirty (idx is then 0).
module tile_prio_enc
  import draw_pkg::*;
(
  input  logic [BOARD_TILES-1:0] bits,
  output logic [INDEX_W-1:0]     idx,
  output logic                   any
);

  // Walk from the top down so the last hit left standing is the lowest index.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = BOARD_TILES - 1; i >= 0; i--) begin
      if (bits[i]) begin
        idx = INDEX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_redraw_scheduler.sv
// board_redraw_scheduler: tracks which of the 16 board tiles need drawing and
// hands them one at a time, lowest index first, to the single-tile drawer.
// Optional macro DIRTY_TRACK_EN: when defined, only tiles that differ from
// what was last drawn are marked dirty; otherwise every board snapshot
// redraws the whole board.
module board_redraw_scheduler
  import draw_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int TILE_W         = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [BOARD_TILES*TILE_W-1:0] board,
  input  logic                          board_valid,
  input  logic                          full_redraw,
  output logic                          sq_start,
  output logic [INDEX_W-1:0]            sq_index,
  output logic [TILE_W-1:0]             sq_value,
  input  logic                          sq_draw_done,
  output logic                          busy,
  output logic                          pass_done,
  output logic                          timeout_err
);

  localparam int BOARD_W = BOARD_TILES * TILE_W;
  localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  sched_state_t           state, state_next;
  logic [BOARD_TILES-1:0] dirty, dirty_next, capture_set;
  logic [BOARD_W-1:0]     pending, pending_next;
  logic [CNT_W-1:0]       cnt;
  logic [INDEX_W-1:0]     enc_idx;
  logic                   enc_any;
  logic                   timeout_hit;
  logic [TILE_W-1:0]      scan_value;

`ifdef DIRTY_TRACK_EN
  logic [BOARD_W-1:0]     shadow;
  logic [BOARD_TILES-1:0] diff_mask;

  for (genvar g = 0; g < BOARD_TILES; g++) begin : g_cmp
    assign diff_mask[g] = board[g*TILE_W +: TILE_W] != shadow[g*TILE_W +: TILE_W];
  end

  // Remember the value handed to the drawer so later snapshots compare against it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
    end else if (state == LAUNCH) begin
      shadow[int'(sq_index)*TILE_W +: TILE_W] <= sq_value;
    end
  end
`endif

  assign timeout_hit = (state == WAIT) && !sq_draw_done && (cnt == CNT_LAST);

  // Merge snapshot captures, launch clears and timeout re-marks; captures win.
  always_comb begin
    capture_set = '0;
    if (board_valid) begin
`ifdef DIRTY_TRACK_EN
      capture_set = diff_mask;
`else
      capture_set = '1;
`endif
    end
    if (full_redraw) begin
      capture_set = '1;
    end
    pending_next = board_valid ? board : pending;
    dirty_next = dirty;
    if (state == LAUNCH) begin
      dirty_next[sq_index] = 1'b0;
    end
    if (timeout_hit) begin
      dirty_next[sq_index] = 1'b1;
    end
    dirty_next = dirty_next | capture_set;
  end

  tile_prio_enc u_enc (
    .bits (dirty_next),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  assign scan_value = TILE_W'(tile_get(WIDE_BOARD_W'(pending_next), TILE_W, enc_idx));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    sq_start   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (dirty != '0) state_next = SCAN;
      SCAN:    state_next = enc_any ? LAUNCH : IDLE;
      LAUNCH: begin
        sq_start   = 1'b1;
        state_next = WAIT;
      end
      WAIT:    if (sq_draw_done || timeout_hit) state_next = SCAN;
      default: state_next = IDLE;
    endcase
  end

  // Dirty set, snapshot, launch operands, timeout counter and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dirty       <= '1;
      pending     <= '0;
      cnt         <= '0;
      sq_index    <= '0;
      sq_value    <= '0;
      pass_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      dirty     <= dirty_next;
      pending   <= pending_next;
      pass_done <= (state == SCAN) && !enc_any;
      if (state == SCAN && enc_any) begin
        sq_index <= enc_idx;
        sq_value <= scan_value;
      end
      if (state == LAUNCH) begin
        cnt <= '0;
      end else if (state == WAIT && cnt != CNT_LAST) begin
        cnt <= cnt + 1'b1;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule
